next_piece_preview: RTL and testbench

Parametrised next-piece preview renderer for the Tetris VGA path. It latches the upcoming piece type on a load pulse and supports 90° clockwise rotation of the preview. The new shape reaches the screen only at a frame boundary, so the preview never tears. A 2-stage pixel pipeline turns the current VGA column/row address into a registered `pixel_on` / `piece_color` pair for the colour mixer.

---
 rtl/next_piece_preview.sv | 198 +++++++++++++++++++
 tb/tb_next_piece_preview.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/next_piece_preview.sv
// next_piece_preview: 4x4 next-piece preview renderer for the VGA path.
// Holds a pending piece (load / clockwise rotate). The pending shape is copied
// to the display registers only at frame start, so the preview never tears.
// A 2-stage pipeline maps the VGA address to registered pixel_on / piece_color.
// Optional macro PREVIEW_BLINK_EN: blink the preview for BLINK_FRAMES frames
// after a newly loaded piece reaches the screen.
module next_piece_preview #(
  parameter int unsigned ORIGIN_X     = 101,
  parameter int unsigned ORIGIN_Y     = 101,
  parameter int unsigned CELL         = 20,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] col_addr_sig,
  input  logic [10:0] row_addr_sig,
  input  logic        load,
  input  logic [2:0]  piece_type,
  input  logic        rotate,
  output logic        pixel_on,
  output logic [2:0]  piece_color,
  output logic        update_pending
);

  localparam int unsigned AW         = 11;
  localparam int unsigned MW         = 16;
  localparam logic [MW-1:0] RESET_MASK = 16'h0720;

  // Cell boundary constants; X4/Y4 are the exclusive right/bottom edges
  localparam logic [AW-1:0] X0 = AW'(ORIGIN_X);
  localparam logic [AW-1:0] X1 = AW'(ORIGIN_X + CELL);
  localparam logic [AW-1:0] X2 = AW'(ORIGIN_X + 2 * CELL);
  localparam logic [AW-1:0] X3 = AW'(ORIGIN_X + 3 * CELL);
  localparam logic [AW-1:0] X4 = AW'(ORIGIN_X + 4 * CELL);
  localparam logic [AW-1:0] Y0 = AW'(ORIGIN_Y);
  localparam logic [AW-1:0] Y1 = AW'(ORIGIN_Y + CELL);
  localparam logic [AW-1:0] Y2 = AW'(ORIGIN_Y + 2 * CELL);
  localparam logic [AW-1:0] Y3 = AW'(ORIGIN_Y + 3 * CELL);
  localparam logic [AW-1:0] Y4 = AW'(ORIGIN_Y + 4 * CELL);

  // Geometry and configuration sanity checks at elaboration
  if (CELL < 2) begin : g_bad_cell
    $error("next_piece_preview: CELL must be >= 2");
  end
  if (ORIGIN_X + 4 * CELL > 2047) begin : g_bad_x
    $error("next_piece_preview: preview window exceeds 11-bit column range");
  end
  if (ORIGIN_Y + 4 * CELL > 2047) begin : g_bad_y
    $error("next_piece_preview: preview window exceeds 11-bit row range");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
    $error("next_piece_preview: BLINK_FRAMES must be 1..255");
  end

  // Shape table lookup by piece code
  function automatic logic [MW-1:0] shape_of(input logic [2:0] t);
    logic [MW-1:0] m;
    case (t)
      3'd0:    m = 16'h0072;
      3'd1:    m = 16'h0660;
      3'd2:    m = 16'h2222;
      3'd3:    m = 16'h0360;
      3'd4:    m = 16'h0630;
      3'd5:    m = 16'h0322;
      3'd6:    m = 16'h0311;
      default: m = 16'h0660;
    endcase
    return m;
  endfunction

  // 90-degree clockwise rotation: new[r][c] = old[3-c][r]
  function automatic logic [MW-1:0] rot_cw(input logic [MW-1:0] m);
    logic [MW-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r * 4 + c] = m[(3 - c) * 4 + r];
      end
    end
    return o;
  endfunction

  logic [MW-1:0] pend_mask;
  logic [2:0]    pend_type;
  logic [1:0]    rot_cnt;
  logic [MW-1:0] disp_mask;
  logic [2:0]    disp_type;

  logic          in_x_q;
  logic          in_y_q;
  logic [1:0]    cx_q;
  logic [1:0]    cy_q;

  logic          frame_start_c;
  logic          in_x_c;
  logic          in_y_c;
  logic [1:0]    cx_c;
  logic [1:0]    cy_c;
  logic          blank_c;

  // Frame start is the (0,0) address cycle
  assign frame_start_c = (col_addr_sig == '0) && (row_addr_sig == '0);

  // Window membership and cell index via boundary comparators
  always_comb begin
    in_x_c = (col_addr_sig >= X0) && (col_addr_sig < X4);
    in_y_c = (row_addr_sig >= Y0) && (row_addr_sig < Y4);
    if (col_addr_sig >= X3)      cx_c = 2'd3;
    else if (col_addr_sig >= X2) cx_c = 2'd2;
    else if (col_addr_sig >= X1) cx_c = 2'd1;
    else                         cx_c = 2'd0;
    if (row_addr_sig >= Y3)      cy_c = 2'd3;
    else if (row_addr_sig >= Y2) cy_c = 2'd2;
    else if (row_addr_sig >= Y1) cy_c = 2'd1;
    else                         cy_c = 2'd0;
  end

  // Pending piece: load wins over a simultaneous rotate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mask <= RESET_MASK;
      pend_type <= 3'd0;
      rot_cnt   <= 2'd0;
    end else if (load) begin
      pend_mask <= shape_of(piece_type);
      pend_type <= piece_type;
      rot_cnt   <= 2'd0;
    end else if (rotate) begin
      pend_mask <= rot_cw(pend_mask);
      rot_cnt   <= rot_cnt + 2'd1;
    end
  end

  // Display copy at frame start; a pulse on that same cycle stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_mask      <= RESET_MASK;
      disp_type      <= 3'd0;
      update_pending <= 1'b0;
    end else if (frame_start_c) begin
      disp_mask      <= pend_mask;
      disp_type      <= pend_type;
      update_pending <= load | rotate;
    end else if (load | rotate) begin
      update_pending <= 1'b1;
    end
  end

`ifdef PREVIEW_BLINK_EN
  logic [7:0] blink_cnt;
  logic       load_seen;

  // Blink counter: restart on a transfer that carries a load, else count down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= 8'd0;
      load_seen <= 1'b0;
    end else if (frame_start_c) begin
      if (load_seen)              blink_cnt <= 8'(BLINK_FRAMES);
      else if (blink_cnt != 8'd0) blink_cnt <= blink_cnt - 8'd1;
      load_seen <= load;
    end else if (load) begin
      load_seen <= 1'b1;
    end
  end

  assign blank_c = blink_cnt[0];
`else
  assign blank_c = 1'b0;
`endif

  // Stage 1: register window flags and cell indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_x_q <= 1'b0;
      in_y_q <= 1'b0;
      cx_q   <= 2'd0;
      cy_q   <= 2'd0;
    end else begin
      in_x_q <= in_x_c;
      in_y_q <= in_y_c;
      cx_q   <= cx_c;
      cy_q   <= cy_c;
    end
  end

  // Stage 2: mask lookup and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on    <= 1'b0;
      piece_color <= 3'd0;
    end else begin
      pixel_on    <= in_x_q & in_y_q & disp_mask[{cy_q, cx_q}] & ~blank_c;
      piece_color <= disp_type;
    end
  end

endmodule

// File: tb/tb_next_piece_preview.sv
// Directed, table-driven bench for next_piece_preview (default geometry,
// BLINK_FRAMES=4). Blink expectations follow PREVIEW_BLINK_EN when defined.
module tb_next_piece_preview;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] col_addr_sig = 11'd500;
  logic [10:0] row_addr_sig = 11'd500;
  logic        load = 1'b0;
  logic [2:0]  piece_type = 3'd0;
  logic        rotate = 1'b0;
  logic        pixel_on;
  logic [2:0]  piece_color;
  logic        update_pending;

  int total = 0;
  int bad   = 0;

  // Expected blink counter and "load since last transfer" flag
  int bm      = 0;
  bit ld_flag = 1'b0;

  typedef struct {
    int         phase;
    int         x;
    int         y;
    logic       on;
    logic [2:0] col;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  next_piece_preview #(
    .ORIGIN_X    (101),
    .ORIGIN_Y    (101),
    .CELL        (20),
    .BLINK_FRAMES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .col_addr_sig  (col_addr_sig),
    .row_addr_sig  (row_addr_sig),
    .load          (load),
    .piece_type    (piece_type),
    .rotate        (rotate),
    .pixel_on      (pixel_on),
    .piece_color   (piece_color),
    .update_pending(update_pending)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    col_addr_sig = 11'd500;
    row_addr_sig = 11'd500;
  endtask

  function automatic logic shown();
`ifdef PREVIEW_BLINK_EN
    return (bm % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic blink_frame_update();
    if (ld_flag) bm = 4;
    else if (bm != 0) bm--;
  endtask

  task automatic frame();
    col_addr_sig = 11'd0;
    row_addr_sig = 11'd0;
    tick();
    idle();
    blink_frame_update();
    ld_flag = 1'b0;
  endtask

  task automatic pulse(input logic l, input logic [2:0] t, input logic r);
    load = l;
    piece_type = t;
    rotate = r;
    tick();
    load = 1'b0;
    rotate = 1'b0;
    if (l) ld_flag = 1'b1;
  endtask

  task automatic scan(input int x, input int y, input logic on, input logic [2:0] col, input string nm);
    col_addr_sig = 11'(x);
    row_addr_sig = 11'(y);
    tick();
    tick();
    chk({nm, " pixel_on"}, 16'(pixel_on), 16'(on & shown()));
    chk({nm, " color"}, 16'(piece_color), 16'(col));
    idle();
  endtask

  task automatic run_phase(input int p);
    foreach (vt[i]) begin
      if (vt[i].phase == p)
        scan(vt[i].x, vt[i].y, vt[i].on, vt[i].col, $sformatf("ph%0d(%0d,%0d)", p, vt[i].x, vt[i].y));
    end
  endtask

  task automatic add(input int p, input int x, input int y, input logic on, input logic [2:0] col);
    vec_t v;
    v.phase = p; v.x = x; v.y = y; v.on = on; v.col = col;
    vt.push_back(v);
  endtask

  initial begin
    logic pat[6];

    // phase 0: reset image 0x0720
    add(0, 115, 125, 1'b0, 3'd0);
    add(0, 125, 125, 1'b1, 3'd0);
    add(0, 101, 141, 1'b1, 3'd0);
    add(0, 160, 141, 1'b1, 3'd0);
    add(0, 170, 145, 1'b0, 3'd0);
    add(0, 125, 105, 1'b0, 3'd0);
    // phase 1: type 2 (0x2222) including cell edges at Y=141
    add(1, 100, 141, 1'b0, 3'd2);
    add(1, 101, 141, 1'b0, 3'd2);
    add(1, 120, 141, 1'b0, 3'd2);
    add(1, 121, 141, 1'b1, 3'd2);
    add(1, 180, 141, 1'b0, 3'd2);
    add(1, 181, 141, 1'b0, 3'd2);
    add(1, 121, 101, 1'b1, 3'd2);
    add(1, 140, 180, 1'b1, 3'd2);
    add(1, 141, 101, 1'b0, 3'd2);
    add(1, 130, 100, 1'b0, 3'd2);
    add(1, 130, 181, 1'b0, 3'd2);
    // phase 2: type 0 rotated once clockwise -> 0x04C4
    add(2, 145, 105, 1'b1, 3'd0);
    add(2, 145, 125, 1'b1, 3'd0);
    add(2, 165, 125, 1'b1, 3'd0);
    add(2, 145, 145, 1'b1, 3'd0);
    add(2, 125, 125, 1'b0, 3'd0);
    add(2, 125, 105, 1'b0, 3'd0);
    // phase 3: four rotations -> back to 0x0072
    add(3, 125, 105, 1'b1, 3'd0);
    add(3, 105, 125, 1'b1, 3'd0);
    add(3, 145, 105, 1'b0, 3'd0);
    add(3, 145, 145, 1'b0, 3'd0);
    // phase 4: type 5 load+rotate collision -> unrotated 0x0322
    add(4, 125, 105, 1'b1, 3'd5);
    add(4, 105, 145, 1'b1, 3'd5);
    add(4, 165, 125, 1'b0, 3'd5);
    add(4, 145, 125, 1'b0, 3'd5);
    // phase 5: type 1 collision -> 0x0660
    add(5, 125, 125, 1'b1, 3'd1);
    add(5, 105, 125, 1'b0, 3'd1);
    add(5, 145, 145, 1'b1, 3'd1);

    // Reset state (asynchronous, visible before any clock edge)
    #2;
    chk("rst pixel_on", 16'(pixel_on), 16'd0);
    chk("rst color", 16'(piece_color), 16'd0);
    chk("rst pending", 16'(update_pending), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_phase(0);

    // Mid-frame load stays pending until frame start
    pulse(1'b1, 3'd2, 1'b0);
    chk("load pending", 16'(update_pending), 16'd1);
    scan(125, 125, 1'b1, 3'd0, "old image kept");
    chk("still pending", 16'(update_pending), 16'd1);
    frame();
    chk("pending cleared", 16'(update_pending), 16'd0);
    run_phase(1);

    // Two-cycle latency with back-to-back addresses
    tick();
    tick();
    col_addr_sig = 11'd125; row_addr_sig = 11'd125;
    tick();
    chk("lat A not yet", 16'(pixel_on), 16'd0);
    col_addr_sig = 11'd145; row_addr_sig = 11'd125;
    tick();
    chk("lat A", 16'(pixel_on), 16'(shown()));
    col_addr_sig = 11'd125; row_addr_sig = 11'd145;
    tick();
    chk("lat B", 16'(pixel_on), 16'd0);
    idle();
    tick();
    chk("lat C", 16'(pixel_on), 16'(shown()));

    // Rotation
    pulse(1'b1, 3'd0, 1'b0);
    pulse(1'b0, 3'd0, 1'b1);
    frame();
    run_phase(2);
    pulse(1'b0, 3'd0, 1'b1);
    pulse(1'b0, 3'd0, 1'b1);
    pulse(1'b0, 3'd0, 1'b1);
    chk("rot pending", 16'(update_pending), 16'd1);
    frame();
    run_phase(3);

    // Load and rotate in the same cycle
    pulse(1'b1, 3'd5, 1'b1);
    frame();
    run_phase(4);
    pulse(1'b1, 3'd1, 1'b1);
    frame();
    run_phase(5);

    // Load coinciding with frame start is deferred one frame
    col_addr_sig = 11'd0; row_addr_sig = 11'd0;
    load = 1'b1; piece_type = 3'd2;
    tick();
    load = 1'b0;
    idle();
    blink_frame_update();
    ld_flag = 1'b1;
    chk("coincide pending", 16'(update_pending), 16'd1);
    run_phase(5);
    frame();
    chk("coincide cleared", 16'(update_pending), 16'd0);
    run_phase(1);

    // Reset mid-frame discards a pending load
    pulse(1'b1, 3'd3, 1'b0);
    chk("pre-reset pending", 16'(update_pending), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst pending", 16'(update_pending), 16'd0);
    chk("async rst color", 16'(piece_color), 16'd0);
    bm = 0;
    ld_flag = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    frame();
    run_phase(0);
    chk("rst no pending", 16'(update_pending), 16'd0);

    // Blink sequence after a load transfer (BLINK_FRAMES=4)
`ifdef PREVIEW_BLINK_EN
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    pulse(1'b1, 3'd2, 1'b0);
    frame();
    for (int f = 0; f < 6; f++) begin
      col_addr_sig = 11'd125; row_addr_sig = 11'd125;
      tick();
      tick();
      chk($sformatf("blink frame %0d", f), 16'(pixel_on), 16'(pat[f]));
      chk($sformatf("blink color %0d", f), 16'(piece_color), 16'd2);
      idle();
      frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
